hmmm_io_port: RTL and testbench
===============================

// Module: hmmm_io_port
// PURPOSE
//  Parametrised pad-side I/O port for the Hmmm core: buffers core write instructions in an output FIFO and
//  serves core read instructions, all over one shared bidirectional pad bus with a 4-phase handshake.
//  Sits between the hmmm core and the user_project_wrapper pads. Owns the pad output-enables and the
//  read/write/halt status pins. Replaces the fixed 16-bit direct pad hookup.
// PARAMETERS
//  DATA_W      16  width of the pad data bus and of core read/write data
//  OUT_DEPTH   4   output FIFO entries; power of two, >=2
//  SYNC_STAGES 2   flip-flop stages on the asynchronous pad_ack input, >=2
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  wr_valid   in   1       core write request; accepted when wr_valid & wr_ready
//  wr_data    in   DATA_W  core write value
//  wr_ready   out  1       FIFO not full (derived from registered count)
//  rd_req     in   1       1-cycle pulse: core requests one input value
//  rd_valid   out  1       1-cycle pulse: rd_data holds a new input value
//  rd_data    out  DATA_W  last captured input value, held until the next capture
//  halt_i     in   1       core has executed halt (level)
//  pad_in     in   DATA_W  pad bus input
//  pad_out    out  DATA_W  pad bus output value
//  pad_oeb    out  DATA_W  pad output enable, active-low, all bits equal
//  pad_ack    in   1       host handshake acknowledge; asynchronous
//  pad_write  out  1       output value valid on the pad bus
//  pad_read   out  1       core waiting for input; bus released
//  pad_halt   out  1       core halted and all output drained
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, pad_oeb all 1, pad_out 0, pad_write/pad_read/pad_halt/rd_valid 0,
//   rd_data 0, read-pending flag 0, sync chain 0. Reset mid-handshake aborts the transfer and drops any
//   queued data.
//  ack_s is pad_ack after SYNC_STAGES flops. rd capture samples pad_in on the cycle ack_s first reads 1.
//  States:
//   IDLE: if FIFO non-empty go to WR_DRIVE (writes have priority, so program order is kept).
//     Otherwise, if read pending and ack_s==0, go to TURN.
//   WR_DRIVE: pad_out=head, pad_oeb=0, pad_write=1. On ack_s==1, pop the FIFO and go to WR_REL.
//   WR_REL: pad_write=0, keep driving head value. On ack_s==0 go to IDLE with pad_oeb=1.
//   TURN: one cycle with pad_oeb=1 (bus turnaround), then go to RD_WAIT.
//   RD_WAIT: pad_read=1. On ack_s==1, latch pad_in into rd_data, pulse rd_valid, clear pending, go to RD_REL.
//   RD_REL: pad_read=0. On ack_s==0 go to IDLE.
//  pad_oeb is 0 only in WR_DRIVE and WR_REL, and never in the same cycle as pad_read=1.
//  Write-to-pad latency from an empty FIFO: push at cycle N, pad_write=1 at N+2 (push N, IDLE N+1, DRIVE N+2).
//  FIFO: push when wr_valid & wr_ready. A push while full is ignored (wr_ready=0 that cycle).
//   Push and pop in the same cycle are both honoured and the count is unchanged. Pointers wrap mod OUT_DEPTH.
//  rd_req while a read is already pending is ignored (only one read outstanding). rd_req in the same
//   cycle as a push is accepted, and the read is serviced after that write drains.
//  pad_halt: registered. Equals halt_i & FIFO empty & state==IDLE & no read pending.
//   Deasserts on the cycle after halt_i falls.
//  ack_s already 1 on entry to a state that needs ack low: wait. A 4-phase handshake is never skipped.
// STRUCTURE
//  hmmm_pkg: localparam state encodings (IDLE, WR_DRIVE, WR_REL, TURN, RD_WAIT, RD_REL), 3-bit state width.
//  Sub-module hmmm_io_fifo (DATA_W, OUT_DEPTH): sync FIFO with push/pop/full/empty/head.
//   The top level holds the FSM, the synchronizer, the read-pending flag and the halt logic.
// TESTING
//  1 Reset mid-WR_DRIVE (FIFO count 3): drop rst_n -> pad_oeb=16'hFFFF and pad_write=0 immediately;
//    after release, wr_ready=1 and no pad_write.
//  2 Push 16'h00AB; host acks each phase after 3 cycles -> pad_out=00AB with pad_write=1 at push+2;
//    pop after sync; pad_oeb=FFFF once ack is low.
//  3 Push 5 values with depth 4 and no ack -> wr_ready=0 after the 4th, 5th ignored;
//    then ack 4 times -> values emitted in order.
//  4 Push 0x1234, then rd_req, host answers the read with 0xBEEF -> pad_read only after the write
//    completes plus one TURN cycle; rd_valid pulses once, rd_data=BEEF; pad_read and pad_oeb=0 never overlap.
//  5 Second rd_req while pending -> exactly one rd_valid.
//  6 halt_i=1 with 2 entries queued -> pad_halt stays 0 until both are acked and in IDLE, then 1;
//    halt_i=0 -> pad_halt=0 next cycle.

Source files
------------

// File: rtl/hmmm_pkg.sv
// Shared constants for the Hmmm pad-side I/O port: handshake FSM state encodings.
package hmmm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_WR_DRIVE = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR_REL   = 3'd2;
  localparam logic [STATE_W-1:0] ST_TURN     = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_RD_REL   = 3'd5;

  // The port owns the pad bus only while a write transfer is in flight.
  function automatic logic drives_bus(input logic [STATE_W-1:0] st);
    return (st == ST_WR_DRIVE) || (st == ST_WR_REL);
  endfunction

endpackage

// File: rtl/hmmm_io_fifo.sv
// Synchronous output FIFO for core writes; head is visible combinationally for the pad driver.
module hmmm_io_fifo #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(OUT_DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hmmm_io_port.sv
// Pad-side I/O port: queues core writes and serves core reads over one shared
// bidirectional pad bus using a 4-phase handshake against an asynchronous ack.
module hmmm_io_port
  import hmmm_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int OUT_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              halt_i,
  input  logic [DATA_W-1:0] pad_in,
  output logic [DATA_W-1:0] pad_out,
  output logic [DATA_W-1:0] pad_oeb,
  input  logic              pad_ack,
  output logic              pad_write,
  output logic              pad_read,
  output logic              pad_halt
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ack_s;
  logic [STATE_W-1:0]     state_reg;
  logic [STATE_W-1:0]     state_next;
  logic                   rd_pending_reg;
  logic                   rd_valid_reg;
  logic [DATA_W-1:0]      rd_data_reg;
  logic [DATA_W-1:0]      pad_out_reg;
  logic                   pad_halt_reg;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_head;
  logic                   fifo_pop;
  logic                   capture;

  hmmm_io_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid & wr_ready),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_ack};
  end
  assign ack_s = sync_reg[SYNC_STAGES-1];

  // Every transfer starts from ack low, so a stuck-high ack never skips a phase.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !ack_s)          state_next = ST_WR_DRIVE;
        else if (rd_pending_reg && !ack_s)  state_next = ST_TURN;
      end
      ST_WR_DRIVE: begin
        if (ack_s) begin
          fifo_pop   = 1'b1;
          state_next = ST_WR_REL;
        end
      end
      ST_WR_REL:  if (!ack_s) state_next = ST_IDLE;
      ST_TURN:    state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (ack_s) begin
          capture    = 1'b1;
          state_next = ST_RD_REL;
        end
      end
      ST_RD_REL:  if (!ack_s) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rd_pending_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      pad_out_reg    <= '0;
      pad_halt_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= capture;
      if (capture)     rd_data_reg    <= pad_in;
      if (capture)     rd_pending_reg <= 1'b0;
      else if (rd_req) rd_pending_reg <= 1'b1;
      // Latch the head on entry so the popped value stays on the bus through release.
      if (state_reg == ST_IDLE && state_next == ST_WR_DRIVE) pad_out_reg <= fifo_head;
      else if (state_next == ST_IDLE)                        pad_out_reg <= '0;
      pad_halt_reg <= halt_i & fifo_empty & (state_reg == ST_IDLE) & ~rd_pending_reg;
    end
  end

  assign wr_ready  = ~fifo_full;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign pad_out   = pad_out_reg;
  assign pad_oeb   = {DATA_W{~drives_bus(state_reg)}};
  assign pad_write = (state_reg == ST_WR_DRIVE);
  assign pad_read  = (state_reg == ST_RD_WAIT);
  assign pad_halt  = pad_halt_reg;

endmodule

// File: tb/tb_hmmm_io_port.sv
// Directed bench for hmmm_io_port: a behavioural host answers handshakes, a queue model checks outputs each cycle.
module tb_hmmm_io_port;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              halt_i = 1'b0;
  logic [DATA_W-1:0] pad_in = '0;
  logic [DATA_W-1:0] pad_out;
  logic [DATA_W-1:0] pad_oeb;
  logic              pad_ack = 1'b0;
  logic              pad_write;
  logic              pad_read;
  logic              pad_halt;

  always #5 clk = ~clk;

  hmmm_io_port #(
    .DATA_W      (DATA_W),
    .OUT_DEPTH   (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .halt_i    (halt_i),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oeb   (pad_oeb),
    .pad_ack   (pad_ack),
    .pad_write (pad_write),
    .pad_read  (pad_read),
    .pad_halt  (pad_halt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Model: queue of accepted writes not yet acknowledged, one outstanding read, ack after two flops.
  logic [DATA_W-1:0] exp_q[$];
  bit                pend_m = 1'b0;
  logic [1:0]        sync_m = 2'b00;
  bit                exp_rdv = 1'b0;
  logic [DATA_W-1:0] exp_rdata = '0;
  int                cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      pend_m = 1'b0;
      sync_m = 2'b00;
      exp_rdv = 1'b0;
      exp_rdata = '0;
    end else begin
      bit new_req;
      new_req = rd_req && !pend_m;
      if (pad_write && sync_m[1] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wr_valid && exp_q.size() < DEPTH) exp_q.push_back(wr_data);
      exp_rdv = 1'b0;
      if (pad_read && sync_m[1]) begin
        exp_rdata = pad_in;
        exp_rdv   = 1'b1;
        pend_m    = 1'b0;
      end
      if (new_req) pend_m = 1'b1;
      sync_m = {sync_m[0], pad_ack};
    end
  end

  // Per-cycle compare against the model.
  bit chk_en = 1'b0;
  int rdv_count = 0;
  int last_drive_cyc = 0;
  int read_gap = 0;
  int read_emit_snap = 0;
  bit prev_read = 1'b0;
  logic [DATA_W-1:0] emitted[$];

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("oeb_uniform", 32'(pad_oeb == '0 || pad_oeb == '1), 32'd1);
      chk("oeb_read_overlap", 32'(pad_oeb == '0 && pad_read), 32'd0);
      chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
      if (pad_write) begin
        if (exp_q.size() > 0) chk("pad_out_head", 32'(pad_out), 32'(exp_q[0]));
        else                  chk("write_when_empty", 32'(pad_write), 32'd0);
      end
      if (pad_read) chk("read_without_req", 32'(pend_m), 32'd1);
      chk("rd_valid", 32'(rd_valid), 32'(exp_rdv));
      chk("rd_data", 32'(rd_data), 32'(exp_rdata));
      if (rd_valid) rdv_count++;
      if (pad_oeb == '0) last_drive_cyc = cyc;
      if (pad_read && !prev_read) begin
        read_gap       = cyc - last_drive_cyc;
        read_emit_snap = emitted.size();
      end
      prev_read = pad_read;
    end
  end

  // Behavioural host: answers each phase after host_delay cycles.
  bit                host_en = 1'b0;
  int                host_delay = 3;
  logic [DATA_W-1:0] rd_answer = '0;
  int                hs = 0;
  int                hd = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pad_ack = 1'b0;
        hs = 0;
      end else if (host_en) begin
        case (hs)
          0: if ((pad_write || pad_read) && !pad_ack) begin hd = host_delay; hs = 1; end
          1: if (hd > 0) hd--;
             else begin
               if (pad_write) emitted.push_back(pad_out);
               else           pad_in = rd_answer;
               pad_ack = 1'b1;
               hs = 2;
             end
          2: if (!pad_write && !pad_read) begin hd = host_delay; hs = 3; end
          3: if (hd > 0) hd--;
             else begin pad_ack = 1'b0; hs = 0; end
          default: hs = 0;
        endcase
      end
    end
  end

  task automatic push(input logic [DATA_W-1:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdv0;
    int e0;
    bit ok;
    logic [DATA_W-1:0] t3_vals[4];
    t3_vals = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_oeb", 32'(pad_oeb), 32'h0000FFFF);
    chk("rst_pad_out", 32'(pad_out), 32'h0);
    chk("rst_pad_write", 32'(pad_write), 32'h0);
    chk("rst_pad_read", 32'(pad_read), 32'h0);
    chk("rst_pad_halt", 32'(pad_halt), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);

    // T1: reset while driving with three entries queued
    push(16'h0A01);
    push(16'h0A02);
    push(16'h0A03);
    chk("t1_driving", 32'(pad_write), 32'h1);
    #2 rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("t1_rst_oeb", 32'(pad_oeb), 32'h0000FFFF);
    chk("t1_rst_write", 32'(pad_write), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("t1_wr_ready", 32'(wr_ready), 32'h1);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pad_write) ok = 1'b0;
    end
    chk("t1_no_write", 32'(ok), 32'h1);

    // T2: single write, latency two cycles from push
    host_en = 1'b1;
    host_delay = 3;
    emitted.delete();
    wr_valid = 1'b1;
    wr_data  = 16'h00AB;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("t2_write_n1", 32'(pad_write), 32'h0);
    @(negedge clk);
    chk("t2_write_n2", 32'(pad_write), 32'h1);
    chk("t2_pad_out", 32'(pad_out), 32'h00AB);
    chk("t2_oeb_drive", 32'(pad_oeb), 32'h0);
    for (int k = 0; k < 100; k++) begin
      if (pad_oeb == '1) break;
      @(negedge clk);
    end
    chk("t2_release", 32'(pad_oeb), 32'h0000FFFF);
    chk("t2_write_low", 32'(pad_write), 32'h0);
    chk("t2_emit_n", 32'(emitted.size()), 32'd1);
    if (emitted.size() > 0) chk("t2_emit_val", 32'(emitted[0]), 32'h00AB);
    repeat (10) @(negedge clk);

    // T3: overfill depth-4 FIFO with no ack, then drain
    host_en = 1'b0;
    emitted.delete();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = (i < 4) ? t3_vals[i] : 16'h0505;
      @(negedge clk);
      if (i == 3) chk("t3_full", 32'(wr_ready), 32'h0);
    end
    wr_valid = 1'b0;
    host_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (emitted.size() >= 4 && pad_oeb == '1) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("t3_emit_n", 32'(emitted.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < emitted.size()) chk("t3_emit_val", 32'(emitted[i]), 32'(t3_vals[i]));
    chk("t3_wr_ready", 32'(wr_ready), 32'h1);

    // T4: write then read in the same cycle; read waits for the write plus turnaround
    rd_answer = 16'hBEEF;
    rdv0 = rdv_count;
    e0 = emitted.size();
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    rd_req   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rdv_count > rdv0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("t4_rdv_once", 32'(rdv_count - rdv0), 32'd1);
    chk("t4_rd_data", 32'(rd_data), 32'h0000BEEF);
    chk("t4_write_first", 32'(read_emit_snap), 32'(e0 + 1));
    chk("t4_turn_gap", 32'(read_gap >= 2), 32'd1);
    if (emitted.size() > e0) chk("t4_emit_val", 32'(emitted[e0]), 32'h1234);

    // T5: extra rd_req while pending are dropped
    rd_answer = 16'h5A5A;
    rdv0 = rdv_count;
    rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (pad_read) break;
      @(negedge clk);
    end
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_rdv_once", 32'(rdv_count - rdv0), 32'd1);
    chk("t5_rd_data", 32'(rd_data), 32'h00005A5A);
    chk("t5_read_idle", 32'(pad_read), 32'h0);

    // T6: halt waits for the queue to drain
    host_en = 1'b0;
    e0 = emitted.size();
    push(16'h0A0A);
    push(16'h0B0B);
    halt_i = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pad_halt) ok = 1'b0;
    end
    chk("t6_halt_blocked", 32'(ok), 32'h1);
    host_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (pad_halt) break;
      @(negedge clk);
    end
    chk("t6_halt_set", 32'(pad_halt), 32'h1);
    chk("t6_drained", 32'(emitted.size() - e0), 32'd2);
    halt_i = 1'b0;
    @(negedge clk);
    chk("t6_halt_clear", 32'(pad_halt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
